// File: rtl/counter_pkg.sv
// Shared constants for the counter bank: step direction, step mode and
// default sizing.
package counter_pkg;

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int INC_WIDTH_DEF  = 2;
    localparam int CHANNELS_DEF   = 4;

endpackage

// File: rtl/counter_cell.sv
// One counter channel: its register, load/step next-value logic and the
// zero/limit flags that the operation would produce.
module counter_cell
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int INC_WIDTH  = INC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic                  i_ldx,
    input  logic                  i_dn,
    input  logic                  i_sat,
    input  logic [INC_WIDTH-1:0]  i_inc,
    input  logic [DATA_WIDTH-1:0] i_x,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_zf_nxt,
    output logic                  o_cf_nxt
);

    logic [DATA_WIDTH-1:0] r_q = '0;
    logic [DATA_WIDTH:0]   w_inc_ext;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_nxt;
    logic                  w_cf;

    // One extra bit on each side catches carry-out and borrow directly.
    assign w_inc_ext = {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc};
    assign w_sum     = {1'b0, r_q} + w_inc_ext;
    assign w_diff    = {1'b0, r_q} - w_inc_ext;

    always_comb begin
        w_nxt = r_q;
        w_cf  = 1'b0;
        if (i_ldx) begin
            w_nxt = i_x;
        end else if (i_dn == DIR_DOWN) begin
            w_cf  = w_diff[DATA_WIDTH];
            w_nxt = (w_cf && i_sat == MODE_SAT) ? '0 : w_diff[DATA_WIDTH-1:0];
        end else begin
            w_cf  = w_sum[DATA_WIDTH];
            w_nxt = (w_cf && i_sat == MODE_SAT) ? '1 : w_sum[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_q <= '0;
        else if (i_we)
            r_q <= w_nxt;
    end

    assign o_q      = r_q;
    assign o_zf_nxt = (w_nxt == '0);
    assign o_cf_nxt = w_cf;

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS counters sharing one load/step port, one tri-state read
// bus and one pair of flags describing the last operation.
module counter_bank
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int INC_WIDTH  = INC_WIDTH_DEF,
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int SEL_WIDTH  = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic                  ldx,
    input  logic                  en,
    input  logic                  dn,
    input  logic                  sat,
    input  logic                  oey,
    input  logic [INC_WIDTH-1:0]  inc,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  zf,
    output logic                  cf
);

    logic [CHANNELS-1:0][DATA_WIDTH-1:0] w_q;
    logic [CHANNELS-1:0]                 w_zf_nxt;
    logic [CHANNELS-1:0]                 w_cf_nxt;
    logic [CHANNELS-1:0]                 w_we;
    logic                                w_sel_ok;
    logic                                w_op;
    logic [DATA_WIDTH-1:0]               w_q_sel;
    logic                                w_zf_sel;
    logic                                w_cf_sel;
    logic                                r_zf = 1'b0;
    logic                                r_cf = 1'b0;

    assign w_sel_ok = (int'(sel) < CHANNELS);
    assign w_op     = (ldx || en) && w_sel_ok;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
        assign w_we[g] = w_op && (int'(sel) == g);

        counter_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .INC_WIDTH  (INC_WIDTH)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_we     (w_we[g]),
            .i_ldx    (ldx),
            .i_dn     (dn),
            .i_sat    (sat),
            .i_inc    (inc),
            .i_x      (x),
            .o_q      (w_q[g]),
            .o_zf_nxt (w_zf_nxt[g]),
            .o_cf_nxt (w_cf_nxt[g])
        );
    end

    // Out-of-range selects fall through to zeros on the read path.
    always_comb begin
        w_q_sel  = '0;
        w_zf_sel = 1'b0;
        w_cf_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) begin
                w_q_sel  = w_q[i];
                w_zf_sel = w_zf_nxt[i];
                w_cf_sel = w_cf_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_zf <= 1'b0;
            r_cf <= 1'b0;
        end else if (w_op) begin
            r_zf <= w_zf_sel;
            r_cf <= w_cf_sel;
        end
    end

    assign zf = r_zf;
    assign cf = r_cf;
    assign y  = oey ? w_q_sel : 'z;

endmodule

// File: tb/tb_counter_bank.sv
// Directed and randomized checks of counter_bank (4 and 5 channels) against
// an arithmetic reference model of the channel values and flags.
module tb_counter_bank;
    import counter_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, ldx = 1'b0, en = 1'b0, dn = 1'b0, sat = 1'b0;
    logic       oey = 1'b1, tb_drv = 1'b0;
    logic [2:0] sel = '0;
    logic [1:0] inc = '0;
    logic [7:0] x = '0;
    tri   [7:0] bus;
    tri   [7:0] y5;
    logic       zf4, cf4, zf5, cf5;

    assign bus = tb_drv ? 8'h3C : 8'hzz;

    counter_bank dut4 (
        .clk(clk), .rst(rst), .sel(sel[1:0]), .ldx(ldx), .en(en), .dn(dn),
        .sat(sat), .oey(oey), .inc(inc), .x(x), .y(bus), .zf(zf4), .cf(cf4)
    );

    counter_bank #(.CHANNELS(5)) dut5 (
        .clk(clk), .rst(rst), .sel(sel), .ldx(ldx), .en(en), .dn(dn),
        .sat(sat), .oey(oey), .inc(inc), .x(x), .y(y5), .zf(zf5), .cf(cf5)
    );

    int checks = 0, errors = 0;
    int m4[4], m5[5];
    bit mz4, mc4, mz5, mc5;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain-integer view of one load or step.
    function automatic void ref_op(input int r, output int nr, output bit z, output bit c);
        int v;
        if (ldx) begin
            nr = int'(x);
            c  = 1'b0;
        end else begin
            v = dn ? r - int'(inc) : r + int'(inc);
            c = (v < 0) || (v > 255);
            if (!c)      nr = v;
            else if (sat) nr = dn ? 0 : 255;
            else         nr = dn ? v + 256 : v - 256;
        end
        z = (nr == 0);
    endfunction

    task automatic cycle();
        int s4, s5;
        s4 = int'(sel[1:0]);
        s5 = int'(sel);
        if (!rst) begin
            foreach (m4[i]) m4[i] = 0;
            foreach (m5[i]) m5[i] = 0;
            {mz4, mc4, mz5, mc5} = '0;
        end else if (ldx || en) begin
            ref_op(m4[s4], m4[s4], mz4, mc4);
            if (s5 < 5) ref_op(m5[s5], m5[s5], mz5, mc5);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        int s5;
        s5 = int'(sel);
        chk({tag, ".zf4"}, {7'b0, zf4}, {7'b0, mz4});
        chk({tag, ".cf4"}, {7'b0, cf4}, {7'b0, mc4});
        chk({tag, ".zf5"}, {7'b0, zf5}, {7'b0, mz5});
        chk({tag, ".cf5"}, {7'b0, cf5}, {7'b0, mc5});
        if (oey && !tb_drv) chk({tag, ".y4"}, bus, 8'(m4[sel[1:0]]));
        if (oey) chk({tag, ".y5"}, y5, (s5 < 5) ? 8'(m5[s5]) : 8'h00);
        if (!oey && tb_drv) chk({tag, ".bus"}, bus, 8'h3C);
    endtask

    task automatic sweep(input string tag);
        rst = 1'b1; ldx = 1'b0; en = 1'b0; oey = 1'b1; tb_drv = 1'b0;
        for (int c = 0; c < 8; c++) begin
            sel = 3'(c);
            #1;
            chk({tag, ".sweep4"}, bus, 8'(m4[c % 4]));
            chk({tag, ".sweep5"}, y5, (c < 5) ? 8'(m5[c]) : 8'h00);
        end
    endtask

    initial begin
        foreach (m4[i]) m4[i] = 0;
        foreach (m5[i]) m5[i] = 0;
        {mz4, mc4, mz5, mc5} = '0;

        #1;
        check_state("powerup");

        rst = 1'b0; ldx = 1'b1; x = 8'h99;
        cycle();
        rst = 1'b1; ldx = 1'b0;
        sweep("reset");
        chk("reset.zf", {7'b0, zf4}, 8'h00);
        chk("reset.cf", {7'b0, cf4}, 8'h00);

        sel = 3'd2; ldx = 1'b1; x = 8'hFE;
        cycle();
        ldx = 1'b0; en = 1'b1; inc = 2'd3; dn = 1'b0; sat = 1'b0;
        cycle();
        chk("wrap_up.y", bus, 8'h01);
        chk("wrap_up.cf", {7'b0, cf4}, 8'h01);
        chk("wrap_up.zf", {7'b0, zf4}, 8'h00);
        check_state("wrap_up");
        sweep("wrap_up");

        sel = 3'd1; ldx = 1'b1; x = 8'h02;
        cycle();
        ldx = 1'b0; en = 1'b1; dn = 1'b1; sat = 1'b1; inc = 2'd3;
        cycle();
        chk("sat_dn.y", bus, 8'h00);
        chk("sat_dn.cf", {7'b0, cf4}, 8'h01);
        chk("sat_dn.zf", {7'b0, zf4}, 8'h01);
        cycle();
        chk("sat_dn2.y", bus, 8'h00);
        chk("sat_dn2.cf", {7'b0, cf4}, 8'h01);
        check_state("sat_dn2");

        sel = 3'd2; inc = 2'd0; dn = 1'b0;
        cycle();
        chk("inc0.y", bus, 8'h01);
        chk("inc0.cf", {7'b0, cf4}, 8'h00);
        chk("inc0.zf", {7'b0, zf4}, 8'h00);

        sel = 3'd0; en = 1'b0; ldx = 1'b1; x = 8'hFF;
        cycle();
        ldx = 1'b0; en = 1'b1; sat = 1'b1; inc = 2'd1;
        cycle();
        chk("sat_up.y", bus, 8'hFF);
        chk("sat_up.cf", {7'b0, cf4}, 8'h01);

        sel = 3'd3; en = 1'b0; ldx = 1'b1; x = 8'h7F;
        #1;
        chk("ld_old.y", bus, 8'h00);
        cycle();
        chk("ld_new.y", bus, 8'h7F);

        ldx = 1'b0; oey = 1'b0; tb_drv = 1'b1;
        #1;
        chk("tri.bus", bus, 8'h3C);
        tb_drv = 1'b0; oey = 1'b1;
        #1;
        chk("tri.y", bus, 8'h7F);
        sel = 3'd0;
        #1;
        chk("sel.zf", {7'b0, zf4}, 8'h00);
        chk("sel.cf", {7'b0, cf4}, 8'h00);

        ldx = 1'b1; en = 1'b1; x = 8'h55;
        cycle();
        chk("prio.y", bus, 8'h55);
        chk("prio.cf", {7'b0, cf4}, 8'h00);
        rst = 1'b0; ldx = 1'b1; en = 1'b0; x = 8'hAA;
        cycle();
        sweep("mid_rst");

        sel = 3'd2; ldx = 1'b1; x = 8'h20;
        cycle();
        sel = 3'd6; x = 8'h11;
        cycle();
        check_state("bad_sel");
        ldx = 1'b0; en = 1'b1; inc = 2'd2;
        cycle();
        check_state("bad_sel_en");

        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom % 25) != 0;
            sel    = 3'($urandom);
            ldx    = ($urandom % 4) == 0;
            en     = 1'($urandom);
            dn     = 1'($urandom);
            sat    = 1'($urandom);
            inc    = 2'($urandom);
            x      = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
            oey    = ($urandom % 4) != 0;
            tb_drv = !oey && 1'($urandom);
            cycle();
            check_state("rand");
            if (n % 50 == 49) sweep("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
